ysyx_23060187_rf_wb_arbiter: RTL and testbench
==============================================

Name: ysyx_23060187_rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 = EXU, port 1 = LSU.
- Keeps a per-register busy scoreboard: set at issue, cleared at writeback.
- Produces read-hazard stall flags for the decode stage.
- Sits between EXU/LSU writeback and the register file; its registered write outputs drive the register file's wdata/waddr/wen.

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb0_valid  input  1  EXU writeback request
- wb0_ready  output  1  EXU request accepted this cycle
- wb0_rd  input  ADDR_WIDTH  EXU destination register
- wb0_data  input  DATA_WIDTH  EXU result
- wb1_valid  input  1  LSU writeback request
- wb1_ready  output  1  LSU request accepted this cycle
- wb1_rd  input  ADDR_WIDTH  LSU destination register
- wb1_data  input  DATA_WIDTH  LSU result
- iss_valid  input  1  decode issues an instruction with a destination
- iss_ready  output  1  issue allowed (destination not busy)
- iss_rd  input  ADDR_WIDTH  destination of issuing instruction
- rs1  input  ADDR_WIDTH  decode source 1 index
- rs2  input  ADDR_WIDTH  decode source 2 index
- rs1_busy  output  1  source 1 hazard; decode must stall
- rs2_busy  output  1  source 2 hazard; decode must stall
- flush  input  1  clears all scoreboard busy bits
- rf_wen  output  1  register file write enable (registered)
- rf_waddr  output  ADDR_WIDTH  register file write address (registered)
- rf_wdata  output  DATA_WIDTH  register file write data (registered)

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All busy bits 0.
  - rr_last=1, so port 0 wins the first contention.
  - Combinational outputs follow from these reset values.
- Arbitration (combinational grant, one grant per cycle):
  - Only one valid: that port is granted.
  - Both valid: the port not equal to rr_last is granted.
  - wbN_ready = grantN; a handshake is valid && ready.
  - rr_last updates to the granted port only on a handshake.
  - No valid: rr_last holds.
- Write stage, 1-cycle latency:
  - On a handshake at edge N: rf_wen=1 (0 if rd==0), rf_waddr=rd, rf_wdata=data, all valid during cycle N..N+1.
  - Register file write lands at edge N+1.
  - No handshake: rf_wen=0 next cycle; rf_waddr and rf_wdata hold.
  - Write stage never stalls; the register file always accepts.
- Scoreboard:
  - busy[0] is hardwired 0.
  - Handshake with rd!=0: busy[rd] cleared at that edge.
  - iss_ready = !busy[iss_rd] || iss_rd==0.
  - iss_valid && iss_ready && iss_rd!=0: busy[iss_rd] set at the edge.
  - Issue rd X and writeback rd X in the same cycle cannot both fire, because X is busy and iss_ready=0.
  - Issue X with writeback Y!=X in the same cycle: both take effect.
  - flush=1: all busy bits cleared at the edge and issue is ignored that cycle. Handshakes and the write stage still proceed.
- Hazard flags:
  - rsN_busy = (rsN!=0) && (busy[rsN] || (rf_wen && rf_waddr==rsN)).
  - The second term covers the one cycle where the write is registered but not yet in the register file.
- Writebacks to rd 0 consume a handshake and advance rr_last, but never assert rf_wen.
- Reset mid-operation: pending write dropped (rf_wen=0) and scoreboard cleared immediately.

Optional Feature:
- Macro: YSYX_23060187_RF_FWD_EN.
- Defined:
  - Adds outputs rs1_fwd and rs2_fwd (1 bit) and fwd_data (DATA_WIDTH).
  - rsN_fwd = rf_wen && rf_waddr==rsN && rsN!=0; fwd_data = rf_wdata.
  - rsN_busy drops the pending-write term, i.e. rsN_busy = (rsN!=0) && busy[rsN].
  - Decode muxes fwd_data instead of stalling.
- Undefined: no forwarding ports; rsN_busy as in Behaviour.

Test Plan:
- Reset, then iss rd=5, then wb0 rd=5 data=0xDEADBEEF
  -> busy[5] set, then cleared at the wb edge.
  -> Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  -> rs1=5 busy for both cycles, clear afterwards.
- wb0 and wb1 both valid for 4 cycles (rd 1..4)
  -> grants 0,1,0,1; each port's ready only in its grant cycle; rf writes in the same order, each 1 cycle after grant.
- wb1 rd=0 data=0x1234
  -> wb1_ready=1, rf_wen stays 0, rr_last=1.
- iss rd=7 while busy[7]=1
  -> iss_ready=0, no state change.
- Same cycle: iss rd=3 and wb0 rd=9 (busy[9]=1)
  -> busy[3]=1, busy[9]=0.
- flush with busy[2]=busy[8]=1 and a wb0 handshake for rd=8
  -> all busy bits cleared; rf write of rd=8 still occurs next cycle.
- rst_n dropped mid-cycle with a pending write
  -> rf_wen=0 immediately.

Source files
------------

// File: rtl/ysyx_23060187_rf_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter for the register-file write port; busy scoreboard and decode hazard flags.
// Latency: registered write 1 cycle after grant; write stage never stalls, losing requester waits (ready low).
// Option YSYX_23060187_RF_FWD_EN: forward the registered write to decode instead of stalling on it.
module ysyx_23060187_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_WIDTH-1:0] wb0_rd,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_WIDTH-1:0] wb1_rd,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  flush,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef YSYX_23060187_RF_FWD_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  rr_last;
  logic                  grant0;
  logic                  grant1;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  pend1;
  logic                  pend2;

  // rr_last names the port that won most recently; the other port wins a tie.
  assign grant0    = wb0_valid && (!wb1_valid || rr_last);
  assign grant1    = wb1_valid && (!wb0_valid || !rr_last);
  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign hs        = grant0 || grant1;
  assign wb_rd     = grant1 ? wb1_rd : wb0_rd;
  assign wb_data   = grant1 ? wb1_data : wb0_data;

  assign iss_ready = !busy[iss_rd] || (iss_rd == '0);

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (hs && (wb_rd != '0))
        busy_nxt[wb_rd] = 1'b0;
      if (iss_valid && iss_ready && (iss_rd != '0))
        busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      rr_last  <= 1'b1;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy   <= busy_nxt;
      rf_wen <= hs && (wb_rd != '0);
      if (hs) begin
        rr_last  <= grant1;
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
    end
  end

  // A registered write is one cycle away from the register file; decode must not read stale data.
  assign pend1 = rf_wen && (rf_waddr == rs1) && (rs1 != '0);
  assign pend2 = rf_wen && (rf_waddr == rs2) && (rs2 != '0);

`ifdef YSYX_23060187_RF_FWD_EN
  assign rs1_busy = (rs1 != '0) && busy[rs1];
  assign rs2_busy = (rs2 != '0) && busy[rs2];
  assign rs1_fwd  = pend1;
  assign rs2_fwd  = pend2;
  assign fwd_data = rf_wdata;
`else
  assign rs1_busy = ((rs1 != '0) && busy[rs1]) || pend1;
  assign rs2_busy = ((rs2 != '0) && busy[rs2]) || pend2;
`endif

endmodule

// File: tb/tb_ysyx_23060187_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, arbitration, write stage, scoreboard, flush, async reset.
module tb_ysyx_23060187_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef YSYX_23060187_RF_FWD_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  ysyx_23060187_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef YSYX_23060187_RF_FWD_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both ports valid; check which one is granted, then the registered write it produced.
  task automatic contend(input string tag, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic e0, input logic [4:0] erd, input logic [31:0] edat);
    wb0_valid = 1'b1; wb0_rd = r0; wb0_data = d0;
    wb1_valid = 1'b1; wb1_rd = r1; wb1_data = d1;
    #1;
    chk({tag, "_rdy0"}, wb0_ready, e0);
    chk({tag, "_rdy1"}, wb1_ready, !e0);
    step();
    chk({tag, "_wen"}, rf_wen, 1);
    chk({tag, "_waddr"}, rf_waddr, erd);
    chk({tag, "_wdata"}, rf_wdata, edat);
  endtask

  initial begin
    rst_n = 1'b0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0; flush = 0;
    #1;
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_ready0", wb0_ready, 0);
    #11 rst_n = 1'b1;

    // Issue rd 5, then write it back from EXU.
    iss_valid = 1; iss_rd = 5; rs1 = 5;
    #1;
    chk("t1_iss_ready", iss_ready, 1);
    chk("t1_rs1_pre", rs1_busy, 0);
    step();
    iss_valid = 0;
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEADBEEF;
    #1;
    chk("t1_busy5_set", iss_ready, 0);
    chk("t1_rs1_busy_a", rs1_busy, 1);
    chk("t1_wb0_ready", wb0_ready, 1);
    chk("t1_wb1_ready", wb1_ready, 0);
    step();
    wb0_valid = 0;
    #1;
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t1_busy5_clr", iss_ready, 1);
    chk("t1_rs1_busy_b", rs1_busy, 1);
    step();
    chk("t1_wen_off", rf_wen, 0);
    chk("t1_waddr_hold", rf_waddr, 5);
    chk("t1_wdata_hold", rf_wdata, 32'hDEADBEEF);
    chk("t1_rs1_free", rs1_busy, 0);

    // LSU writeback to x0: handshakes, never writes, and makes port 0 win the next tie.
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'h1234;
    #1;
    chk("x0_ready", wb1_ready, 1);
    step();
    wb1_valid = 0;
    chk("x0_wen", rf_wen, 0);
    chk("x0_wdata", rf_wdata, 32'h1234);

    // Contention: grants alternate 0,1,0,1.
    contend("c0", 5'd1, 32'hA1, 5'd2, 32'hB2, 1'b1, 5'd1, 32'hA1);
    contend("c1", 5'd3, 32'hA3, 5'd2, 32'hB2, 1'b0, 5'd2, 32'hB2);
    contend("c2", 5'd3, 32'hA3, 5'd4, 32'hB4, 1'b1, 5'd3, 32'hA3);
    contend("c3", 5'd6, 32'hA6, 5'd4, 32'hB4, 1'b0, 5'd4, 32'hB4);
    wb0_valid = 0; wb1_valid = 0;
    step();
    chk("c_idle_wen", rf_wen, 0);

    // Re-issue to a busy destination is refused.
    iss_valid = 1; iss_rd = 7;
    step();
    #1;
    chk("busy7_iss_ready", iss_ready, 0);
    step();
    iss_valid = 0; rs1 = 7;
    #1;
    chk("busy7_hold", iss_ready, 0);
    chk("busy7_rs1", rs1_busy, 1);

    // Issue rd 3 alongside a writeback of busy rd 9.
    iss_valid = 1; iss_rd = 9;
    step();
    iss_rd = 3; wb0_valid = 1; wb0_rd = 9; wb0_data = 32'h99;
    #1;
    chk("same_iss_ready", iss_ready, 1);
    chk("same_wb0_ready", wb0_ready, 1);
    step();
    iss_valid = 0; wb0_valid = 0;
    iss_rd = 3; #1;
    chk("same_busy3", iss_ready, 0);
    iss_rd = 9; #1;
    chk("same_busy9", iss_ready, 1);

    // Flush with busy 2 and 8 plus a writeback of rd 8; a concurrent issue is ignored.
    iss_valid = 1; iss_rd = 2;
    step();
    iss_rd = 8;
    step();
    iss_rd = 10; flush = 1;
    wb0_valid = 1; wb0_rd = 8; wb0_data = 32'h88;
    #1;
    chk("fl_wb0_ready", wb0_ready, 1);
    step();
    flush = 0; iss_valid = 0; wb0_valid = 0;
    chk("fl_wen", rf_wen, 1);
    chk("fl_waddr", rf_waddr, 8);
    chk("fl_wdata", rf_wdata, 32'h88);
    rs1 = 2; rs2 = 7;
    iss_rd = 2; #1;
    chk("fl_busy2", iss_ready, 1);
    iss_rd = 8; #1;
    chk("fl_busy8", iss_ready, 1);
    iss_rd = 10; #1;
    chk("fl_iss10_ignored", iss_ready, 1);
    chk("fl_rs1_2", rs1_busy, 0);
    chk("fl_rs2_7", rs2_busy, 0);

    // Asynchronous reset with a write pending and rd 12 busy.
    iss_valid = 1; iss_rd = 12;
    wb0_valid = 1; wb0_rd = 11; wb0_data = 32'hCAFE;
    step();
    iss_valid = 0; wb0_valid = 0;
    chk("ar_wen_pre", rf_wen, 1);
    chk("ar_busy12_pre", iss_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wen", rf_wen, 0);
    chk("ar_waddr", rf_waddr, 0);
    chk("ar_busy12", iss_ready, 1);
    #2 rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
